fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_pkg.sv | 15 +
 rtl/fifo_uart_tx_if.sv | 23 ++
 rtl/fifo_uart_tx_bit_timer.sv | 29 ++
 rtl/fifo_uart_tx.sv | 126 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// State encoding is fixed so it can be probed by debug logic.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the async FIFO (master) and its consumer (slave).
// The consumer pops with fifo_r_inc while fifo_empty is low.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_r_inc;

  modport master (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_r_inc
  );

  modport slave (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_r_inc
  );

endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// uart_bit_timer: counts clk cycles while enabled, pulses bit_done every period cycles.
// Restarts from zero on load, so a new frame always begins on a fresh bit boundary.
module uart_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [PRESCALE_WIDTH-1:0] period,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;

  // period is never zero here; the caller clamps it to at least 1
  assign bit_done = en && (cnt_q == period - PRESCALE_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load || !en || bit_done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the async FIFO read port and serializes each as a UART frame.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fifo_uart_tx_if.slave             fifo,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_WIDTH-1:0] period_q;
  logic                      tx_q, tx_d;
  logic                      busy_q;
  logic                      bit_done;
  logic                      pop;
  logic                      par_go;
  logic                      par_bit;

  // Fetch only from IDLE or on the final stop cycle, which keeps it to one pop per frame
  assign pop = rst_n && !fifo.fifo_empty
             && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  assign fifo.fifo_r_inc = pop;

  uart_bit_timer #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q != IDLE),
    .load     (pop),
    .period   (period_q),
    .bit_done (bit_done)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (pop) begin
      par_en_q  <= par_en;
      par_bit_q <= (^fifo.fifo_rd_data) ^ par_typ;
    end
  end

  assign par_go  = par_en_q;
  assign par_bit = par_bit_q;
`else
  logic unused_par_cfg;
  assign unused_par_cfg = par_en ^ par_typ;
  assign par_go         = 1'b0;
  assign par_bit        = TX_IDLE_LEVEL;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = TX_IDLE_LEVEL;
    case (state_q)
      IDLE:   if (pop) state_d = START;
      START:  if (bit_done) begin
                state_d   = DATA;
                bit_cnt_d = '0;
              end
      DATA:   if (bit_done) begin
                if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  state_d = par_go ? PARITY : STOP;
                end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
              end
      PARITY: if (bit_done) state_d = STOP;
      STOP:   if (bit_done) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = fifo.fifo_rd_data;

    // Line level is registered from the next state so it lines up with the state change
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      period_q  <= PRESCALE_WIDTH'(1);
      tx_q      <= TX_IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != IDLE);
      if (pop) period_q <= (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model feeds words, a scoreboard
// holds pushed words and each received frame is compared cycle by cycle.
module tb_fifo_uart_tx;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [5:0] prescale = 6'd4;
  logic       par_en   = 1'b0;
  logic       par_typ  = 1'b0;
  logic       tx_out;
  logic       busy;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pops   = 0;
  logic [7:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  fifo_uart_tx_if #(.DATA_WIDTH(8)) u_if ();

  assign u_if.fifo_empty   = (wr_ptr == rd_ptr);
  assign u_if.fifo_rd_data = mem[rd_ptr % 64];

  fifo_uart_tx #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fifo     (u_if.slave),
    .prescale (prescale),
    .par_en   (par_en),
    .par_typ  (par_typ),
    .tx_out   (tx_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (u_if.fifo_r_inc === 1'b1) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  // Waits for the start bit, then checks every cycle of the frame against the scoreboard word
  task automatic check_frame(input string name, input int p, input bit par_on,
                             input logic par_bit, input int max_wait, output int waited);
    logic [7:0]  w;
    logic [10:0] bits;
    logic [7:0]  got;
    int          nb;
    int          bad;
    int          busy_bad;
    waited = 0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: actual empty, required a pending word", name);
      return;
    end
    w  = exp_q.pop_front();
    nb = par_on ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = w[i];
    if (par_on) bits[9] = par_bit;
    @(negedge clk);
    while (tx_out !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    if (tx_out !== 1'b0) begin
      errors++;
      $display("FAIL %s start_timeout: actual tx_out=%b, required 0 within %0d cycles", name, tx_out, max_wait);
      return;
    end
    bad = 0;
    busy_bad = 0;
    got = '0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < p; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (tx_out !== bits[b]) bad++;
        if (busy !== 1'b1) busy_bad++;
        if (c == 0 && b >= 1 && b <= 8) got[b-1] = tx_out;
      end
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL %s waveform: actual %0d bad cycles, required 0 (word %h, p=%0d, bits=%0d)", name, bad, w, p, nb);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_in_frame: actual %0d low cycles, required 0", name, busy_bad);
    end
    checks++;
    if (got !== w) begin
      errors++;
      $display("FAIL %s data: actual %h, required %h", name, got, w);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    int waited;
    prescale = 6'd2;
    @(negedge clk);
    push_word(8'hC3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0 || u_if.fifo_r_inc !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_hold: actual %0d bad cycles, required tx=1 busy=0 r_inc=0", bad);
    end
    checks++;
    if (pops != 0) begin
      errors++;
      $display("FAIL reset_pops: actual %0d, required 0", pops);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (u_if.fifo_r_inc !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rinc: actual %b, required 1", u_if.fifo_r_inc);
    end
    check_frame("reset_release", 2, 1'b0, 1'b1, 2, waited);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_idle: actual busy=%b tx=%b, required busy=0 tx=1", busy, tx_out);
    end
  endtask

  task automatic test_single();
    int waited;
    int p0;
    prescale = 6'd4;
    par_en   = 1'b0;
    @(negedge clk);
    p0 = pops;
    push_word(8'hA5);
    #1;
    checks++;
    if (u_if.fifo_r_inc !== 1'b1) begin
      errors++;
      $display("FAIL single_rinc: actual %b, required 1", u_if.fifo_r_inc);
    end
    @(posedge clk);
    #1;
    prescale = 6'd7;
    par_en   = 1'b1;
    check_frame("single", 4, 1'b0, 1'b1, 0, waited);
    checks++;
    if (u_if.fifo_r_inc !== 1'b0) begin
      errors++;
      $display("FAIL single_last_stop_rinc: actual %b, required 0", u_if.fifo_r_inc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_out !== 1'b1 || pops != p0 + 1) begin
      errors++;
      $display("FAIL single_end: actual busy=%b tx=%b pops=%0d, required 0 1 %0d", busy, tx_out, pops - p0, 1);
    end
    par_en = 1'b0;
  endtask

  task automatic test_parity();
    int waited;
    prescale = 6'd3;
    for (int t = 0; t < 2; t++) begin
      par_en  = 1'b1;
      par_typ = t[0];
      @(negedge clk);
      push_word(8'h07);
      // even -> parity bit 1, odd -> parity bit 0 for three set bits
      check_frame(t == 0 ? "parity_even" : "parity_odd", 3, PAR_BUILT, (t == 0) ? 1'b1 : 1'b0, 2, waited);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx_out !== 1'b1) begin
        errors++;
        $display("FAIL parity_end_%0d: actual busy=%b tx=%b, required 0 1", t, busy, tx_out);
      end
    end
    par_en  = 1'b0;
    par_typ = 1'b0;
  endtask

  task automatic test_back_to_back();
    int waited;
    int p0;
    prescale = 6'd2;
    @(negedge clk);
    p0 = pops;
    push_word(8'h11);
    push_word(8'h22);
    check_frame("b2b_first", 2, 1'b0, 1'b1, 2, waited);
    checks++;
    if (u_if.fifo_r_inc !== 1'b1 || pops != p0 + 1) begin
      errors++;
      $display("FAIL b2b_last_stop_rinc: actual r_inc=%b pops=%0d, required 1 1", u_if.fifo_r_inc, pops - p0);
    end
    check_frame("b2b_second", 2, 1'b0, 1'b1, 0, waited);
    checks++;
    if (waited != 0) begin
      errors++;
      $display("FAIL b2b_gap: actual %0d idle cycles, required 0", waited);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pops != p0 + 2) begin
      errors++;
      $display("FAIL b2b_end: actual busy=%b pops=%0d, required 0 2", busy, pops - p0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited;
    int n = 0;
    logic [7:0] lost;
    prescale = 6'd4;
    @(negedge clk);
    push_word(8'h3C);
    push_word(8'h5A);
    while (tx_out !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    // 4 start cycles + 3 data bits + 1 cycle lands inside data bit 3
    for (int i = 0; i < 17; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || u_if.fifo_r_inc !== 1'b0) begin
      errors++;
      $display("FAIL midreset_force: actual tx=%b busy=%b r_inc=%b, required 1 0 0", tx_out, busy, u_if.fifo_r_inc);
    end
    lost = exp_q.pop_front();
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b1;
    check_frame("midreset_next", 4, 1'b0, 1'b1, 2, waited);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lost !== 8'h3C) begin
      errors++;
      $display("FAIL midreset_end: actual busy=%b lost=%h, required 0 3c", busy, lost);
    end
  endtask

  task automatic test_empty_edge_prescale();
    int waited;
    int bad = 0;
    int p0;
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || u_if.fifo_r_inc !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || pops != p0) begin
      errors++;
      $display("FAIL empty_idle: actual %0d bad cycles pops=%0d, required 0 0", bad, pops - p0);
    end
    prescale = 6'd0;
    @(negedge clk);
    push_word(8'h96);
    check_frame("prescale_zero", 1, 1'b0, 1'b1, 2, waited);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL prescale_zero_end: actual busy=%b tx=%b, required 0 1", busy, tx_out);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_empty_edge_prescale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
